axi_wrap_rd_merge: RTL and testbench
====================================

AXI_WRAP_RD_MERGE -- requirements
Module: axi_wrap_rd_merge

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32: width of MC read data and AXI RDATA; legal values 32, 64, 128.
REQ-002 SHALL have parameter C_ID_WIDTH, default 4: width of the AXI ID.
REQ-003 SHALL have parameter C_MC_BURST_LEN, default 1: 1 for BL4/BC4, 2 for BL8.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; all logic SHALL be clocked on the rising edge of clk.
REQ-005 clk  input  1  the only clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 desc_valid  input  1  burst descriptor valid.
REQ-008 desc_ready  output  1  descriptor accepted when high with desc_valid.
REQ-009 desc_id  input  C_ID_WIDTH  AXI ID of the burst.
REQ-010 desc_len  input  4  AXI ARLEN[3:0] (beats-1).
REQ-011 desc_offset  input  1  ARADDR[C_AXSIZE], the BL8 pad-offset bit.
REQ-012 mc_rd_valid  input  1  MC read beat valid.
REQ-013 mc_rd_ready  output  1  MC read beat consumed.
REQ-014 mc_rd_data  input  C_DATA_WIDTH  MC read beat data.
REQ-015 s_axi_rvalid / s_axi_rready  output / input  1 / 1  AXI R handshake.
REQ-016 s_axi_rdata  output  C_DATA_WIDTH  R data.
REQ-017 s_axi_rid  output  C_ID_WIDTH  R ID.
REQ-018 s_axi_rresp  output  2  R response.
REQ-019 s_axi_rlast  output  1  last beat of the burst.
REQ-020 busy  output  1  burst in flight or R beat held.

Function
REQ-021 SHALL implement a two-state FSM, IDLE and DATA; desc_ready SHALL be 1 only in IDLE.
REQ-022 On desc_valid&desc_ready the block SHALL latch id and len, latch off_eff = desc_offset & (C_MC_BURST_LEN==2), clear in_idx and out_idx, and go to DATA.
REQ-023 The MC beat total SHALL be T = len+1+2*off_eff (max 18); in_idx SHALL be 5 bits and out_idx SHALL be 4 bits.
REQ-024 An MC beat SHALL be dropped when off_eff=1 and (in_idx==0 or in_idx==T-1); all other beats are kept.
REQ-025 mc_rd_ready SHALL be (state==DATA) & (drop | ~s_axi_rvalid | s_axi_rready).
REQ-026 A dropped beat SHALL be consumed with no change to the R outputs.
REQ-027 A kept beat accepted in cycle N SHALL appear on s_axi_rvalid/rdata in cycle N+1, with rid set to the latched id and rlast = (out_idx==len); out_idx SHALL then increment.
REQ-028 The R payload SHALL be held stable while s_axi_rvalid=1 and s_axi_rready=0.
REQ-029 s_axi_rvalid SHALL clear on s_axi_rready unless a new kept beat loads in the same cycle, in which case rvalid SHALL stay 1 with the new payload.
REQ-030 Consuming the beat with in_idx==T-1 SHALL return the FSM to IDLE in the next cycle; a new descriptor SHALL NOT be accepted in that same cycle.
REQ-031 In IDLE, a held final R beat SHALL remain valid until s_axi_rready; a new descriptor may be accepted during that time.
REQ-032 desc_len values other than 1, 3, 7 or 15 SHALL be processed with the same counting rule and SHALL NOT raise an error.
REQ-033 s_axi_rresp SHALL be 2'b00 at all times.
REQ-034 busy SHALL be (state==DATA) | s_axi_rvalid.
REQ-035 mc_rd_valid while in IDLE SHALL be ignored (mc_rd_ready=0).

Reset
REQ-036 Assertion of reset_n=0 SHALL immediately force IDLE, with in_idx, out_idx, s_axi_rvalid, s_axi_rlast, s_axi_rdata, s_axi_rid, mc_rd_ready and busy all 0.
REQ-037 desc_ready SHALL be 0 while reset_n=0 and 1 from the first clock edge after deassertion.
REQ-038 A burst in progress at reset SHALL be discarded without an rlast; the first descriptor after reset SHALL be processed normally.

Verification
REQ-039 BL1, len=3, off=1, MC beats A0..A3, rready=1 -> R beats A0..A3, rlast on A3 only, no drops, desc_ready back to 1 one cycle after A3 is consumed.
REQ-040 BL2, len=3, off=1, MC beats D0..D5 -> R beats D1..D4, rlast on D4; D0 and D5 are consumed without rvalid.
REQ-041 BL2, len=15, off=0, 16 MC beats -> 16 R beats, rlast on beat 15, zero drops.
REQ-042 BL1, len=7, rready held 0 for 3 cycles after beat 2 -> rdata/rid stable, mc_rd_ready=0, no beat lost or duplicated.
REQ-043 reset_n pulsed low after 2 R beats of a len=7 burst -> rvalid=0 and busy=0 asynchronously; a following len=1, id=5 burst yields 2 beats with rid=5.
REQ-044 Back-to-back descriptors id=1, len=1 and id=2, len=3 -> rid 1,1,2,2,2,2, rlast on beats 2 and 6.

Source files
------------

// File: rtl/axi_wrap_rd_merge.sv
// axi_wrap_rd_merge
// Merges memory-controller read beats into an AXI read-data (R) stream for one
// burst at a time. When the burst was issued to the MC with a BL8 pad offset
// (off_eff=1), the first and last MC beats are padding: they are consumed and
// discarded. Every other beat is forwarded through a single-entry R register.
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   desc_valid/desc_ready          burst descriptor handshake
//   desc_id/desc_len/desc_offset   AXI ID, ARLEN[3:0], BL8 pad-offset bit
//   mc_rd_valid/ready/data         MC read beat stream
//   s_axi_r*                       AXI R channel (rresp always OKAY)
//   busy                           burst in flight or R beat still held
module axi_wrap_rd_merge #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_ID_WIDTH     = 4,
  parameter int C_MC_BURST_LEN = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [C_ID_WIDTH-1:0]   desc_id,
  input  logic [3:0]              desc_len,
  input  logic                    desc_offset,
  input  logic                    mc_rd_valid,
  output logic                    mc_rd_ready,
  input  logic [C_DATA_WIDTH-1:0] mc_rd_data,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [C_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [C_ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    busy
);

  localparam logic BL8 = (C_MC_BURST_LEN == 2);

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    arm_q, arm_d;
  logic [C_ID_WIDTH-1:0]   id_q, id_d;
  logic [3:0]              len_q, len_d;
  logic                    off_q, off_d;
  logic [4:0]              in_idx_q, in_idx_d;
  logic [3:0]              out_idx_q, out_idx_d;
  logic                    rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_ID_WIDTH-1:0]   rid_q, rid_d;
  logic                    rlast_q, rlast_d;

  logic [4:0] tot;
  logic       last_in;
  logic       drop;
  logic       desc_fire;
  logic       mc_fire;
  logic       keep_fire;

  // MC beat total: ARLEN+1 data beats plus two pad beats when offset.
  assign tot       = {1'b0, len_q} + 5'd1 + {3'b000, off_q, 1'b0};
  assign last_in   = (in_idx_q == (tot - 5'd1));
  assign drop      = off_q & ((in_idx_q == 5'd0) | last_in);
  assign desc_fire = desc_valid & desc_ready;
  assign mc_fire   = mc_rd_valid & mc_rd_ready;
  assign keep_fire = mc_fire & ~drop;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state. Leaving DATA takes a cycle, so a descriptor can never
  // be accepted on the same edge that consumes the final MC beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (desc_fire) state_d = DATA;
      DATA:    if (mc_fire && last_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. arm_q holds desc_ready low until the first edge after reset.
  // Pad beats are always accepted; kept beats need a free or draining R slot.
  always_comb begin
    desc_ready  = arm_q & (state_q == IDLE);
    mc_rd_ready = (state_q == DATA) & (drop | ~rvalid_q | s_axi_rready);
    busy        = (state_q == DATA) | rvalid_q;
  end

  // Datapath next-state
  always_comb begin
    arm_d     = 1'b1;
    id_d      = id_q;
    len_d     = len_q;
    off_d     = off_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;

    if (desc_fire) begin
      id_d      = desc_id;
      len_d     = desc_len;
      off_d     = desc_offset & BL8;
      in_idx_d  = 5'd0;
      out_idx_d = 4'd0;
    end

    if (mc_fire) in_idx_d = in_idx_q + 5'd1;

    // A new kept beat overrides the clear so rvalid stays up back-to-back.
    if (keep_fire) begin
      rvalid_d  = 1'b1;
      rdata_d   = mc_rd_data;
      rid_d     = id_q;
      rlast_d   = (out_idx_q == len_q);
      out_idx_d = out_idx_q + 4'd1;
    end else if (s_axi_rready) begin
      rvalid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q     <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      off_q     <= 1'b0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
    end else begin
      arm_q     <= arm_d;
      id_q      <= id_d;
      len_q     <= len_d;
      off_q     <= off_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rid    = rid_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rresp  = 2'b00;

endmodule

// File: tb/tb_axi_wrap_rd_merge.sv
// Bench for axi_wrap_rd_merge: two instances (BL4 and BL8 configurations)
// driven from one directed/randomized sequence. Expected R beats are derived
// from the burst rules: MC beat list, drop the pad beats when the BL8 offset
// applies, rlast on the (len+1)-th forwarded beat.
module tb_axi_wrap_rd_merge;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]         dv, dr, doff, mv, mr, rv, rr, rl, bsy;
  logic [1:0][IW-1:0] did, rid;
  logic [1:0][3:0]    dlen;
  logic [1:0][DW-1:0] md, rd;
  logic [1:0][1:0]    rresp;

  axi_wrap_rd_merge #(.C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_MC_BURST_LEN(1)) u_bl1 (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(dv[0]), .desc_ready(dr[0]), .desc_id(did[0]), .desc_len(dlen[0]),
    .desc_offset(doff[0]), .mc_rd_valid(mv[0]), .mc_rd_ready(mr[0]), .mc_rd_data(md[0]),
    .s_axi_rvalid(rv[0]), .s_axi_rready(rr[0]), .s_axi_rdata(rd[0]), .s_axi_rid(rid[0]),
    .s_axi_rresp(rresp[0]), .s_axi_rlast(rl[0]), .busy(bsy[0]));

  axi_wrap_rd_merge #(.C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_MC_BURST_LEN(2)) u_bl2 (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(dv[1]), .desc_ready(dr[1]), .desc_id(did[1]), .desc_len(dlen[1]),
    .desc_offset(doff[1]), .mc_rd_valid(mv[1]), .mc_rd_ready(mr[1]), .mc_rd_data(md[1]),
    .s_axi_rvalid(rv[1]), .s_axi_rready(rr[1]), .s_axi_rdata(rd[1]), .s_axi_rid(rid[1]),
    .s_axi_rresp(rresp[1]), .s_axi_rlast(rl[1]), .busy(bsy[1]));

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } rbeat_t;

  rbeat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // rmode: 0 = rready/mc_valid always 1, 1 = random both, 2 = rready low for
  // 3 cycles once 2 beats are taken. abort_after>0 returns once that many R
  // beats are taken (burst left in flight).
  task automatic run_burst(input int s, input logic [IW-1:0] id, input logic [3:0] len,
                           input logic off, input int rmode, input int abort_after);
    int offe, tot, k, cyc, mi, nacc, stall;
    bit pending, prev_hold;
    logic [DW-1:0] d, prev_d;
    logic [IW-1:0] prev_id;
    logic [DW-1:0] mcd[$];
    rbeat_t b;
    offe = (off && s == 1) ? 1 : 0;
    tot  = int'(len) + 1 + 2 * offe;
    k = 0; mi = 0; nacc = 0; stall = 0; cyc = 0;
    pending = 0; prev_hold = 0; prev_d = '0; prev_id = '0;
    exp_q.delete();
    for (int i = 0; i < tot; i++) begin
      d = $urandom;
      mcd.push_back(d);
      if (!(offe == 1 && (i == 0 || i == tot - 1))) begin
        exp_q.push_back('{id: id, data: d, last: (k == int'(len))});
        k++;
      end
    end

    @(negedge clk);
    dv[s] = 1'b1; did[s] = id; dlen[s] = len; doff[s] = off;
    #1;
    while (!dr[s] && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (cyc >= 50) begin
      chk("desc_timeout", 64'd0, 64'd1);
      dv[s] = 1'b0;
      return;
    end

    cyc = 0;
    while ((mi < tot || exp_q.size() > 0) && cyc < 500) begin
      @(negedge clk); cyc++;
      dv[s] = 1'b0;
      if (pending) begin
        chk("desc_ready_after_last", 64'(dr[s]), 64'd1);
        pending = 0;
      end
      case (rmode)
        0: rr[s] = 1'b1;
        1: rr[s] = ($urandom_range(0, 3) != 0);
        default: begin
          if (nacc == 2 && stall < 3) begin rr[s] = 1'b0; stall++; end
          else rr[s] = 1'b1;
        end
      endcase
      mv[s] = (mi < tot) && (rmode == 1 ? ($urandom_range(0, 2) != 0) : 1'b1);
      md[s] = mv[s] ? mcd[mi] : '0;
      #1;
      if (prev_hold) begin
        chk("hold_valid", 64'(rv[s]), 64'd1);
        chk("hold_data", 64'(rd[s]), 64'(prev_d));
        chk("hold_id", 64'(rid[s]), 64'(prev_id));
      end
      if (rmode == 2 && !rr[s]) begin
        chk("stall_rvalid", 64'(rv[s]), 64'd1);
        chk("stall_mc_ready", 64'(mr[s]), 64'd0);
      end
      if (rv[s] && rr[s]) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          b = exp_q.pop_front();
          chk("rdata", 64'(rd[s]), 64'(b.data));
          chk("rid", 64'(rid[s]), 64'(b.id));
          chk("rlast", 64'(rl[s]), 64'(b.last));
          chk("rresp", 64'(rresp[s]), 64'd0);
        end
        nacc++;
      end
      prev_hold = rv[s] && !rr[s];
      prev_d = rd[s]; prev_id = rid[s];
      if (mv[s] && mr[s]) begin
        mi++;
        if (mi == tot) pending = 1;
      end
      if (abort_after > 0 && nacc == abort_after) return;
    end
    if (cyc >= 500) chk("burst_timeout", 64'd0, 64'd1);

    @(negedge clk);
    mv[s] = 1'b0; rr[s] = 1'b1;
    #1;
    if (pending) chk("desc_ready_after_last", 64'(dr[s]), 64'd1);
    chk("end_rvalid", 64'(rv[s]), 64'd0);
    chk("end_busy", 64'(bsy[s]), 64'd0);
    chk("end_desc_ready", 64'(dr[s]), 64'd1);
  endtask

  initial begin
    dv = '0; doff = '0; mv = '0; rr = '0; did = '0; dlen = '0; md = '0;
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_rvalid", 64'(rv[s]), 64'd0);
      chk("rst_busy", 64'(bsy[s]), 64'd0);
      chk("rst_mc_ready", 64'(mr[s]), 64'd0);
      chk("rst_desc_ready", 64'(dr[s]), 64'd0);
      chk("rst_rlast", 64'(rl[s]), 64'd0);
      chk("rst_rdata", 64'(rd[s]), 64'd0);
      chk("rst_rid", 64'(rid[s]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("desc_ready_pre_edge", 64'(dr), 64'd0);
    @(posedge clk); #1;
    chk("desc_ready_post_edge", 64'(dr), 64'd3);

    // MC beats offered while idle are not taken
    @(negedge clk); mv = 2'b11; #1;
    chk("idle_mc_ready", 64'(mr), 64'd0);
    @(negedge clk); mv = 2'b00;

    run_burst(0, 4'd3, 4'd3, 1'b1, 0, 0);   // BL4 ignores offset
    run_burst(1, 4'd4, 4'd3, 1'b1, 0, 0);   // BL8 with pad drops
    run_burst(1, 4'd6, 4'd15, 1'b0, 0, 0);  // BL8 long, no drops
    run_burst(0, 4'd7, 4'd7, 1'b0, 2, 0);   // R backpressure

    // reset in the middle of a burst
    run_burst(0, 4'd9, 4'd7, 1'b0, 0, 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rv[0]), 64'd0);
    chk("midrst_busy", 64'(bsy[0]), 64'd0);
    chk("midrst_mc_ready", 64'(mr[0]), 64'd0);
    chk("midrst_rlast", 64'(rl[0]), 64'd0);
    dv = '0; mv = '0;
    exp_q.delete();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_desc_ready", 64'(dr[0]), 64'd1);
    run_burst(0, 4'd5, 4'd1, 1'b0, 0, 0);

    // consecutive descriptors
    run_burst(0, 4'd1, 4'd1, 1'b0, 0, 0);
    run_burst(0, 4'd2, 4'd3, 1'b0, 0, 0);

    // randomized bursts on both configurations, including odd lengths
    for (int i = 0; i < 24; i++) begin
      run_burst(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom), 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
